// File: rtl/ni_tdm_slot_scheduler_if.sv
// ni_tdm_slot_scheduler_if: endpoint out-queue heads in, pops and registered NoC injection out
interface ni_tdm_slot_scheduler_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CT_LINKS = 2,
  parameter int NUM_EP = 4
);
  logic [NUM_EP-1:0][CT_LINKS-1:0][FLIT_WIDTH-1:0] ep_flit;
  logic [NUM_EP-1:0][CT_LINKS-1:0] ep_valid;
  logic [NUM_EP-1:0][CT_LINKS-1:0] ep_checkpoint;
  logic [NUM_EP-1:0][CT_LINKS-1:0] ep_rd_select;
  logic [CT_LINKS-1:0][FLIT_WIDTH-1:0] noc_flit;
  logic [CT_LINKS-1:0] noc_valid;
  logic [CT_LINKS-1:0] noc_checkpoint;
  modport master (
    input  ep_flit, ep_valid, ep_checkpoint,
    output ep_rd_select, noc_flit, noc_valid, noc_checkpoint
  );
  modport slave (
    output ep_flit, ep_valid, ep_checkpoint,
    input  ep_rd_select, noc_flit, noc_valid, noc_checkpoint
  );
endinterface

// File: rtl/ni_tdm_slot_scheduler.sv
// ni_tdm_slot_scheduler: walks a per-link slot table with a free-running counter and injects the owning endpoint's flit
module ni_tdm_slot_scheduler #(
  parameter int FLIT_WIDTH = 32,
  parameter int CT_LINKS = 2,
  parameter int NUM_EP = 4,
  parameter int LUT_SIZE = 8,
  localparam int EP_WIDTH = $clog2(NUM_EP),
  localparam int SLOT_WIDTH = $clog2(LUT_SIZE)
) (
  input  logic clk_noc,
  input  logic rst_noc_n,
  input  logic [CT_LINKS-1:0] link_enabled,
  input  logic slot_sync,
  ni_tdm_slot_scheduler_if.master bus,
  input  logic cfg_en,
  input  logic cfg_link,
  input  logic [SLOT_WIDTH-1:0] cfg_slot,
  input  logic [EP_WIDTH-1:0] cfg_ep,
  input  logic cfg_entry_valid,
  output logic cfg_err,
  output logic [SLOT_WIDTH-1:0] cur_slot
);
  logic [CT_LINKS-1:0][LUT_SIZE-1:0] tbl_valid;
  logic [CT_LINKS-1:0][LUT_SIZE-1:0][EP_WIDTH-1:0] tbl_ep;
  logic [CT_LINKS-1:0][EP_WIDTH-1:0] sel;
  logic [CT_LINKS-1:0] active;
  logic [CT_LINKS-1:0] go;
  logic cfg_ok;
  if (CT_LINKS != 2 || NUM_EP < 2 || LUT_SIZE < 2) begin : g_bad_cfg
    $fatal(1, "ni_tdm_slot_scheduler: needs CT_LINKS==2, NUM_EP>=2, LUT_SIZE>=2");
  end
  // Out-of-range writes never reach the table, so sel is always a legal endpoint
  assign cfg_ok = int'(cfg_slot) < LUT_SIZE && int'(cfg_ep) < NUM_EP;
  for (genvar i = 0; i < CT_LINKS; i++) begin : g_link
    assign sel[i] = tbl_ep[i][cur_slot];
    assign active[i] = link_enabled[i] & tbl_valid[i][cur_slot];
    assign go[i] = active[i] & bus.ep_valid[sel[i]][i];
  end
  always_comb begin
    bus.ep_rd_select = '0;
    for (int i = 0; i < CT_LINKS; i++) bus.ep_rd_select[sel[i]][i] = active[i];
  end
  always_ff @(posedge clk_noc or negedge rst_noc_n)
    if (!rst_noc_n) cur_slot <= '0;
    else cur_slot <= slot_sync || cur_slot == SLOT_WIDTH'(LUT_SIZE - 1) ? '0 : cur_slot + SLOT_WIDTH'(1);
  always_ff @(posedge clk_noc or negedge rst_noc_n)
    if (!rst_noc_n) begin
      tbl_valid <= '0;
      tbl_ep <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_en & ~cfg_ok;
      if (cfg_en && cfg_ok) begin
        tbl_valid[cfg_link][cfg_slot] <= cfg_entry_valid;
        tbl_ep[cfg_link][cfg_slot] <= cfg_ep;
      end
    end
  always_ff @(posedge clk_noc or negedge rst_noc_n)
    if (!rst_noc_n) begin
      bus.noc_valid <= '0;
      bus.noc_checkpoint <= '0;
      bus.noc_flit <= '0;
    end else
      for (int i = 0; i < CT_LINKS; i++) begin
        bus.noc_valid[i] <= go[i];
        bus.noc_checkpoint[i] <= go[i] & bus.ep_checkpoint[sel[i]][i];
        bus.noc_flit[i] <= go[i] ? bus.ep_flit[sel[i]][i] : '0;
      end
endmodule

// File: tb/tb_ni_tdm_slot_scheduler.sv
// tb_ni_tdm_slot_scheduler: two instances (8 slots/4 eps and 6 slots/3 eps) against a slot-table reference model
module tb_ni_tdm_slot_scheduler;
  logic clk_noc = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] link_enabled = 2'b11;
  logic slot_sync = 1'b0;
  logic cfg_en[2] = '{1'b0, 1'b0};
  logic cfg_link[2] = '{1'b0, 1'b0};
  logic [2:0] cfg_slot[2] = '{3'd0, 3'd0};
  logic [1:0] cfg_ep[2] = '{2'd0, 2'd0};
  logic cfg_v[2] = '{1'b0, 1'b0};
  logic cfg_err8, cfg_err6;
  logic [2:0] cur8, cur6;
  int n_chk = 0;
  int n_pass = 0;
  int lut[2] = '{8, 6};
  int nep[2] = '{4, 3};
  bit mv[2][2][8];
  int mep[2][2][8];
  int mslot[2];
  bit [1:0] mnv[2];
  bit [1:0] mnc[2];
  logic [31:0] mnf[2][2];
  bit merr[2];
  always #5 clk_noc = ~clk_noc;
  ni_tdm_slot_scheduler_if i8 ();
  ni_tdm_slot_scheduler_if #(.NUM_EP(3)) i6 ();
  assign i6.ep_flit = i8.ep_flit[2:0];
  assign i6.ep_valid = i8.ep_valid[2:0];
  assign i6.ep_checkpoint = i8.ep_checkpoint[2:0];
  ni_tdm_slot_scheduler d8 (
    .clk_noc(clk_noc), .rst_noc_n(rst_n), .link_enabled(link_enabled), .slot_sync(slot_sync), .bus(i8),
    .cfg_en(cfg_en[0]), .cfg_link(cfg_link[0]), .cfg_slot(cfg_slot[0]), .cfg_ep(cfg_ep[0]),
    .cfg_entry_valid(cfg_v[0]), .cfg_err(cfg_err8), .cur_slot(cur8)
  );
  ni_tdm_slot_scheduler #(.LUT_SIZE(6), .NUM_EP(3)) d6 (
    .clk_noc(clk_noc), .rst_noc_n(rst_n), .link_enabled(link_enabled), .slot_sync(slot_sync), .bus(i6),
    .cfg_en(cfg_en[1]), .cfg_link(cfg_link[1]), .cfg_slot(cfg_slot[1]), .cfg_ep(cfg_ep[1]),
    .cfg_entry_valid(cfg_v[1]), .cfg_err(cfg_err6), .cur_slot(cur6)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic bit act(int k, int l);
    return link_enabled[l] && mv[k][l][mslot[k]];
  endfunction
  function automatic int owner(int k, int l);
    return mep[k][l][mslot[k]];
  endfunction
  function automatic bit inj(int k, int l);
    return act(k, l) && i8.ep_valid[owner(k, l)][l] === 1'b1;
  endfunction
  // Reference: a slot owns a link when enabled and its entry is valid; the owner's head is registered out
  always @(posedge clk_noc or negedge rst_n)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        mslot[k] <= 0;
        merr[k] <= 1'b0;
        mnv[k] <= 2'b00;
        mnc[k] <= 2'b00;
        for (int l = 0; l < 2; l++) begin
          mnf[k][l] <= 32'h0;
          for (int s = 0; s < 8; s++) begin
            mv[k][l][s] <= 1'b0;
            mep[k][l][s] <= 0;
          end
        end
      end else begin
        for (int l = 0; l < 2; l++) begin
          mnv[k][l] <= inj(k, l);
          mnc[k][l] <= inj(k, l) && i8.ep_checkpoint[owner(k, l)][l];
          mnf[k][l] <= inj(k, l) ? i8.ep_flit[owner(k, l)][l] : 32'h0;
        end
        merr[k] <= cfg_en[k] && !(int'(cfg_slot[k]) < lut[k] && int'(cfg_ep[k]) < nep[k]);
        if (cfg_en[k] && int'(cfg_slot[k]) < lut[k] && int'(cfg_ep[k]) < nep[k]) begin
          mv[k][cfg_link[k]][cfg_slot[k]] <= cfg_v[k];
          mep[k][cfg_link[k]][cfg_slot[k]] <= int'(cfg_ep[k]);
        end
        mslot[k] <= slot_sync ? 0 : (mslot[k] + 1) % lut[k];
      end
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit [7:0] es = 8'h0;
      for (int l = 0; l < 2; l++) if (act(k, l)) es[owner(k, l) * 2 + l] = 1'b1;
      chk($sformatf("cur_slot[%0d]", k), 64'(k ? cur6 : cur8), 64'(mslot[k]));
      chk($sformatf("rd_select[%0d]", k), 64'(k ? 8'(i6.ep_rd_select) : 8'(i8.ep_rd_select)), 64'(es));
      chk($sformatf("noc_valid[%0d]", k), 64'(k ? i6.noc_valid : i8.noc_valid), 64'(mnv[k]));
      chk($sformatf("noc_checkpoint[%0d]", k), 64'(k ? i6.noc_checkpoint : i8.noc_checkpoint), 64'(mnc[k]));
      chk($sformatf("cfg_err[%0d]", k), 64'(k ? cfg_err6 : cfg_err8), 64'(merr[k]));
      for (int l = 0; l < 2; l++)
        chk($sformatf("noc_flit[%0d][%0d]", k, l), 64'(k ? i6.noc_flit[l] : i8.noc_flit[l]), 64'(mnf[k][l]));
    end
  endtask
  always @(negedge clk_noc) check_all();
  task automatic step();
    @(posedge clk_noc);
    #2;
  endtask
  task automatic cfg_write(input int k, input bit link, input int slot, input int ep, input bit v);
    step();
    cfg_en[k] = 1'b1;
    cfg_link[k] = link;
    cfg_slot[k] = 3'(slot);
    cfg_ep[k] = 2'(ep);
    cfg_v[k] = v;
    step();
    cfg_en[k] = 1'b0;
  endtask
  task automatic wait_slot(input int s);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_noc);
      if (int'(cur8) == s) return;
    end
    chk("wait_slot_timeout", 64'(cur8), 64'(s));
  endtask
  initial begin
    i8.ep_flit = '0;
    i8.ep_valid = '0;
    i8.ep_checkpoint = '0;
    repeat (3) @(negedge clk_noc);
    chk("rst_cur_slot", 64'(cur8), 64'd0);
    chk("rst_noc_valid", 64'(i8.noc_valid), 64'd0);
    chk("rst_rd_select", 64'(i8.ep_rd_select), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk_noc);
    chk("post_rst_slot", 64'(cur8), 64'd0);
    @(negedge clk_noc);
    chk("first_edge_slot", 64'(cur8), 64'd1);
    repeat (9) step();
    // Duplicate injection of one endpoint on both links in slot 3
    i8.ep_flit[2][0] = 32'hCAFE0001;
    i8.ep_flit[2][1] = 32'hCAFE0001;
    i8.ep_valid[2] = 2'b11;
    i8.ep_checkpoint[2] = 2'b11;
    cfg_write(0, 1'b0, 3, 2, 1'b1);
    cfg_write(0, 1'b1, 3, 2, 1'b1);
    wait_slot(3);
    chk("dup_select", 64'(i8.ep_rd_select[2]), 64'd3);
    chk("dup_select_others", 64'(8'(i8.ep_rd_select) & 8'hCF), 64'd0);
    @(negedge clk_noc);
    chk("dup_valid", 64'(i8.noc_valid), 64'd3);
    chk("dup_flit0", 64'(i8.noc_flit[0]), 64'hCAFE0001);
    chk("dup_flit1", 64'(i8.noc_flit[1]), 64'hCAFE0001);
    chk("dup_ckpt", 64'(i8.noc_checkpoint), 64'd3);
    step();
    i8.ep_valid[2] = 2'b00;
    wait_slot(3);
    chk("empty_select", 64'(i8.ep_rd_select[2]), 64'd3);
    @(negedge clk_noc);
    chk("empty_valid", 64'(i8.noc_valid), 64'd0);
    chk("empty_flit", 64'(i8.noc_flit[0]), 64'd0);
    step();
    i8.ep_valid[2] = 2'b11;
    wait_slot(4);
    step();
    slot_sync = 1'b1;
    step();
    slot_sync = 1'b0;
    @(negedge clk_noc);
    chk("sync_at5", 64'(cur8), 64'd0);
    wait_slot(6);
    step();
    slot_sync = 1'b1;
    step();
    slot_sync = 1'b0;
    @(negedge clk_noc);
    chk("sync_at7", 64'(cur8), 64'd0);
    cfg_write(1, 1'b0, 7, 1, 1'b1);
    @(negedge clk_noc);
    chk("err_slot_pulse", 64'(cfg_err6), 64'd1);
    @(negedge clk_noc);
    chk("err_slot_clear", 64'(cfg_err6), 64'd0);
    cfg_write(1, 1'b1, 2, 3, 1'b1);
    @(negedge clk_noc);
    chk("err_ep_pulse", 64'(cfg_err6), 64'd1);
    cfg_write(1, 1'b0, 5, 2, 1'b1);
    @(negedge clk_noc);
    chk("ok_write_no_err", 64'(cfg_err6), 64'd0);
    wait_slot(2);
    step();
    link_enabled = 2'b01;
    @(negedge clk_noc);
    chk("link_drop_select", 64'(i8.ep_rd_select[2]), 64'd1);
    @(negedge clk_noc);
    chk("link_drop_valid", 64'(i8.noc_valid), 64'd1);
    step();
    link_enabled = 2'b11;
    wait_slot(3);
    @(posedge clk_noc);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_slot", 64'(cur8), 64'd0);
    chk("async_rst_valid", 64'(i8.noc_valid), 64'd0);
    chk("async_rst_flit", 64'(i8.noc_flit[0]), 64'd0);
    chk("async_rst_select", 64'(i8.ep_rd_select), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int e = 0; e < 4; e++)
        for (int l = 0; l < 2; l++) i8.ep_flit[e][l] = $urandom();
      i8.ep_valid = 8'($urandom());
      i8.ep_checkpoint = 8'($urandom());
      link_enabled = ($urandom_range(0, 9) == 0) ? 2'($urandom()) : 2'b11;
      slot_sync = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 2; k++) begin
        cfg_en[k] = ($urandom_range(0, 3) == 0);
        cfg_link[k] = 1'($urandom());
        cfg_slot[k] = 3'($urandom());
        cfg_ep[k] = 2'($urandom());
        cfg_v[k] = ($urandom_range(0, 3) != 0);
      end
    end
    step();
    @(negedge clk_noc);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
